obs_align_monitor: RTL and testbench

Downstream observation checker for the source/target codeblock pair in a compiler-optimization case study. It consumes the public outputs and stutter flags of both codeblocks and aligns the two traces by discarding stuttered cycles. It compares the non-stuttered observations pairwise in order and raises sticky verdict flags: an observational mismatch, or an alignment-buffer overflow. The result is a synthesizable monitor whose flags the model-checking flow observes as plain outputs.

---
 rtl/obs_align_if.sv | 29 ++
 rtl/obs_align_monitor.sv | 96 +++++++++
 tb/tb_obs_align_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/obs_align_if.sv
// Observation/stutter inputs and verdict outputs of the source/target alignment monitor.
// master drives the traces; slave is the monitor itself.
interface obs_align_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
);
  localparam int unsigned SW = $clog2(DEPTH + 1) + 1;

  logic                 en;
  logic [W-1:0]         obs_src;
  logic                 st_src;
  logic [W-1:0]         obs_tar;
  logic                 st_tar;
  logic                 cmp_valid;
  logic                 cmp_equal;
  logic                 mismatch;
  logic                 overflow;
  logic signed [SW-1:0] skew;

  modport master (
    output en, obs_src, st_src, obs_tar, st_tar,
    input  cmp_valid, cmp_equal, mismatch, overflow, skew
  );

  modport slave (
    input  en, obs_src, st_src, obs_tar, st_tar,
    output cmp_valid, cmp_equal, mismatch, overflow, skew
  );
endinterface

// File: rtl/obs_align_monitor.sv
// Aligns source and target observation traces by dropping stuttered cycles, then compares the
// surviving events pairwise in order and raises sticky mismatch / overflow verdicts.
module obs_align_monitor #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input logic        clk,
  input logic        rst_n,
  obs_align_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [W-1:0] mem_src [DEPTH];
  logic [W-1:0] mem_tar [DEPTH];

  logic [PW-1:0] rd_src_q, rd_src_d, wr_src_q, wr_src_d;
  logic [PW-1:0] rd_tar_q, rd_tar_d, wr_tar_q, wr_tar_d;
  logic [CW-1:0] cnt_src_q, cnt_src_d, cnt_tar_q, cnt_tar_d;

  logic                 cmp_valid_q, cmp_equal_q, mismatch_q, overflow_q;
  logic                 cmp_equal_d, mismatch_d, overflow_d;
  logic signed [SW-1:0] skew_q, skew_d;

  logic pop, head_eq;
  logic req_src, req_tar, acc_src, acc_tar, drop_src, drop_tar;

  always_comb begin
    pop     = bus.en && (cnt_src_q != '0) && (cnt_tar_q != '0);
    // Heads come from storage only; same-cycle inputs are never bypassed into the compare.
    head_eq = (mem_src[rd_src_q] == mem_tar[rd_tar_q]);

    req_src  = bus.en && !bus.st_src;
    req_tar  = bus.en && !bus.st_tar;
    // A full FIFO still accepts a push when the same edge frees a slot.
    acc_src  = req_src && ((cnt_src_q != Full) || pop);
    acc_tar  = req_tar && ((cnt_tar_q != Full) || pop);
    drop_src = req_src && !acc_src;
    drop_tar = req_tar && !acc_tar;

    wr_src_d  = acc_src ? wr_src_q + PW'(1) : wr_src_q;
    wr_tar_d  = acc_tar ? wr_tar_q + PW'(1) : wr_tar_q;
    rd_src_d  = pop ? rd_src_q + PW'(1) : rd_src_q;
    rd_tar_d  = pop ? rd_tar_q + PW'(1) : rd_tar_q;
    cnt_src_d = cnt_src_q + CW'(acc_src) - CW'(pop);
    cnt_tar_d = cnt_tar_q + CW'(acc_tar) - CW'(pop);

    skew_d = $signed({1'b0, cnt_src_d}) - $signed({1'b0, cnt_tar_d});

    cmp_equal_d = pop ? head_eq : cmp_equal_q;
    mismatch_d  = mismatch_q || (pop && !head_eq);
    overflow_d  = overflow_q || drop_src || drop_tar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_src_q    <= '0;
      wr_src_q    <= '0;
      rd_tar_q    <= '0;
      wr_tar_q    <= '0;
      cnt_src_q   <= '0;
      cnt_tar_q   <= '0;
      skew_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_equal_q <= 1'b0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_src_q    <= rd_src_d;
      wr_src_q    <= wr_src_d;
      rd_tar_q    <= rd_tar_d;
      wr_tar_q    <= wr_tar_d;
      cnt_src_q   <= cnt_src_d;
      cnt_tar_q   <= cnt_tar_d;
      skew_q      <= skew_d;
      cmp_valid_q <= pop;
      cmp_equal_q <= cmp_equal_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (acc_src) mem_src[wr_src_q] <= bus.obs_src;
    if (acc_tar) mem_tar[wr_tar_q] <= bus.obs_tar;
  end

  assign bus.cmp_valid = cmp_valid_q;
  assign bus.cmp_equal = cmp_equal_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.overflow  = overflow_q;
  assign bus.skew      = skew_q;
endmodule

// File: tb/tb_obs_align_monitor.sv
// Randomized and directed bench for obs_align_monitor against a queue-based trace model.
module tb_obs_align_monitor;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obs_align_if #(.DEPTH(DEPTH), .W(W)) ifc ();

  obs_align_monitor #(.DEPTH(DEPTH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: two event queues, pairwise compare of heads, bounded by DEPTH.
  logic [W-1:0] q_src[$];
  logic [W-1:0] q_tar[$];
  logic [W-1:0] stream[$];
  bit m_valid, m_equal, m_mis, m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_src.delete();
    q_tar.delete();
    m_valid = 0;
    m_equal = 0;
    m_mis   = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit e, input logic [W-1:0] os, input bit ss,
                            input logic [W-1:0] ot, input bit stt);
    logic [W-1:0] hs, ht;
    m_valid = 0;
    if (e) begin
      if (q_src.size() > 0 && q_tar.size() > 0) begin
        hs = q_src.pop_front();
        ht = q_tar.pop_front();
        m_valid = 1;
        m_equal = (hs == ht);
        if (hs != ht) m_mis = 1;
      end
      if (!ss) begin
        if (q_src.size() < DEPTH) q_src.push_back(os);
        else m_ovf = 1;
      end
      if (!stt) begin
        if (q_tar.size() < DEPTH) q_tar.push_back(ot);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    check("cmp_valid", int'(ifc.cmp_valid), int'(m_valid));
    check("cmp_equal", int'(ifc.cmp_equal), int'(m_equal));
    check("mismatch", int'(ifc.mismatch), int'(m_mis));
    check("overflow", int'(ifc.overflow), int'(m_ovf));
    check("skew", int'(ifc.skew), q_src.size() - q_tar.size());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(ifc.cmp_valid), 0);
    check({tag, "_equal"}, int'(ifc.cmp_equal), 0);
    check({tag, "_mis"}, int'(ifc.mismatch), 0);
    check({tag, "_ovf"}, int'(ifc.overflow), 0);
    check({tag, "_skew"}, int'(ifc.skew), 0);
  endtask

  // Starts and ends just after a falling edge.
  task automatic step(input bit e, input logic [W-1:0] os, input bit ss,
                      input logic [W-1:0] ot, input bit stt);
    ifc.en      = e;
    ifc.obs_src = os;
    ifc.st_src  = ss;
    ifc.obs_tar = ot;
    ifc.st_tar  = stt;
    @(posedge clk);
    model_step(e, os, ss, ot, stt);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 1'b1, '0, 1'b1);
  endtask

  // Reset asserted mid-low-phase: outputs must clear before any edge.
  task automatic mid_reset();
    #2;
    rst_n      = 1'b0;
    ifc.st_src = 1'b1;
    ifc.st_tar = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit e, ss, stt;
    logic [W-1:0] os, ot;
    int ps, pt;
    ifc.en = 1'b0;
    ifc.obs_src = '0;
    ifc.st_src = 1'b1;
    ifc.obs_tar = '0;
    ifc.st_tar = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous equal traffic.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("steady_mis", int'(ifc.mismatch), 0);

    // Unequal pair, tar late by 3 cycles.
    mid_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("unequal_skew", int'(ifc.skew), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("unequal_mis", int'(ifc.mismatch), 1);

    // Stutter alignment.
    mid_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, '0, 1'b1, '0, 1'b1);
    check("stutter_peak", int'(ifc.skew), 3);
    step(1'b1, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, '0, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("stutter_mis", int'(ifc.mismatch), 0);

    // Overflow: fifth src event is dropped.
    mid_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("pre_ovf", int'(ifc.overflow), 0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("ovf_flag", int'(ifc.overflow), 1);
    check("ovf_skew", int'(ifc.skew), DEPTH);
    step(1'b1, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("ovf_mis", int'(ifc.mismatch), 0);
    check("ovf_sticky", int'(ifc.overflow), 1);

    // Enable gating, then asynchronous reset mid-cycle.
    mid_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("en_skew", int'(ifc.skew), 2);
    check("en_valid", int'(ifc.cmp_valid), 0);
    mid_reset();

    // Wrap-around: 3*DEPTH+1 alternating events, tar two cycles behind.
    for (int c = 0; c < 3 * DEPTH + 3; c++) begin
      ss  = !(c < 3 * DEPTH + 1);
      stt = !(c >= 2);
      step(1'b1, W'(c % 2), ss, W'((c + 2) % 2), stt);
    end
    idle(3);
    check("wrap_mis", int'(ifc.mismatch), 0);
    check("wrap_ovf", int'(ifc.overflow), 0);
    check("wrap_skew", int'(ifc.skew), 0);

    // Random segments; odd ones replay the src stream on tar so compares mostly agree.
    for (int seg = 0; seg < 4; seg++) begin
      mid_reset();
      stream.delete();
      case (seg)
        0: begin ps = 30; pt = 30; end
        1: begin ps = 20; pt = 60; end
        2: begin ps = 60; pt = 20; end
        default: begin ps = 10; pt = 10; end
      endcase
      for (int c = 0; c < 150; c++) begin
        e   = ($urandom_range(0, 9) != 0);
        ss  = ($urandom_range(0, 99) < ps);
        stt = ($urandom_range(0, 99) < pt);
        os  = W'($urandom);
        ot  = W'($urandom);
        if (seg % 2 == 1) begin
          if (stream.size() == 0) stt = 1'b1;
          else ot = stream[0];
          if (e && !stt) void'(stream.pop_front());
          if (e && !ss) stream.push_back(os);
        end
        step(e, os, ss, ot, stt);
      end
      idle(DEPTH + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end
endmodule
